// File: rtl/coax_frame_rx.sv
// rtl/coax_frame_rx.sv - 3270 coax Manchester frame receiver with word FIFO and sticky error code
module coax_frame_rx #(
    parameter int CLOCKS_PER_BIT = 8,
    parameter int DEPTH          = 8,
    parameter bit PARITY_ODD     = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx,
    input  logic                     read,
    input  logic                     clear_error,
    output logic [9:0]               data,
    output logic                     last,
    output logic                     data_available,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     active,
    output logic                     error,
    output logic [2:0]               error_code
);

    localparam int HALF = CLOCKS_PER_BIT / 2;
    localparam int TOL  = CLOCKS_PER_BIT / 4;
    localparam int CW   = $clog2(4 * CLOCKS_PER_BIT) + 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int AW1  = AW + 1;
    localparam logic [CW-1:0]  CNT_MAX  = '1;
    localparam logic [AW1-1:0] FULL_CNT = AW1'(DEPTH);

    localparam logic [2:0] E_MID = 3'd1;
    localparam logic [2:0] E_PAR = 3'd2;
    localparam logic [2:0] E_END = 3'd3;
    localparam logic [2:0] E_OVF = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SYNC,
        S_DATA,
        S_PARITY,
        S_END,
        S_ERROR
    } state_t;

    state_t          r_state, w_state_nx;
    logic            r_sync1, r_sync2, r_rx_d;
    logic [1:0]      r_sub, w_sub_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [2:0]      r_ones, w_ones_nx;
    logic [9:0]      r_shift, w_shift_nx;
    logic [3:0]      r_bits, w_bits_nx;
    logic [9:0]      r_hold, w_hold_nx;
    logic            r_hold_vld, w_hold_vld_nx;
    logic [2:0]      r_err_code, w_err_nx, w_fault;

    logic [10:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_rd, r_wr;
    logic [AW1-1:0]  r_count;

    logic            w_rise, w_fall, w_edge, w_mid, w_bit_to;
    logic            w_full, w_pop, w_push_req, w_push, w_push_last;
    logic [9:0]      w_push_data;

    function automatic logic in_win(input logic [CW-1:0] c, input int tgt);
        return (int'(c) >= tgt - TOL) && (int'(c) <= tgt + TOL);
    endfunction

    function automatic logic past_win(input logic [CW-1:0] c, input int tgt);
        return int'(c) > tgt + TOL;
    endfunction

    assign w_rise   = r_sync2 & ~r_rx_d;
    assign w_fall   = ~r_sync2 & r_rx_d;
    assign w_edge   = w_rise | w_fall;
    // r_cnt counts clocks since the last bit-clock reference; mid-bit edges land at CLOCKS_PER_BIT
    assign w_mid    = w_edge && in_win(r_cnt, CLOCKS_PER_BIT);
    assign w_bit_to = past_win(r_cnt, CLOCKS_PER_BIT);
    assign w_full   = (r_count == FULL_CNT);
    assign w_pop    = read && (r_count != '0);

    always_comb begin
        w_state_nx    = r_state;
        w_sub_nx      = r_sub;
        w_cnt_nx      = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        w_ones_nx     = r_ones;
        w_shift_nx    = r_shift;
        w_bits_nx     = r_bits;
        w_hold_nx     = r_hold;
        w_hold_vld_nx = r_hold_vld;
        w_err_nx      = r_err_code;
        w_fault       = 3'd0;
        w_push_req    = 1'b0;
        w_push_last   = 1'b0;
        w_push_data   = r_hold;
        w_push        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_cnt_nx = CW'(1);
                    if (r_ones != 3'd0 && in_win(r_cnt, CLOCKS_PER_BIT)) begin
                        if (r_ones == 3'd4) begin
                            w_state_nx = S_START;
                            w_sub_nx   = 2'd0;
                            w_ones_nx  = 3'd0;
                        end else begin
                            w_ones_nx = r_ones + 3'd1;
                        end
                    end else begin
                        w_ones_nx = 3'd1;
                    end
                end else if (w_fall) begin
                    if (!in_win(r_cnt, HALF)) w_ones_nx = 3'd0;
                end else if (r_ones != 3'd0 && w_bit_to) begin
                    w_ones_nx = 3'd0;
                end
            end

            // Extra bit-1 cells are tolerated until the low-3/high-3 violation shows up
            S_START: begin
                case (r_sub)
                    2'd0: begin
                        if (w_fall && in_win(r_cnt, HALF)) begin
                            w_sub_nx = 2'd1;
                            w_cnt_nx = CW'(1);
                        end else if (w_edge || past_win(r_cnt, HALF)) begin
                            w_state_nx = S_IDLE;
                        end
                    end
                    2'd1: begin
                        if (w_rise && in_win(r_cnt, HALF)) begin
                            w_sub_nx = 2'd0;
                            w_cnt_nx = CW'(1);
                        end else if (w_rise && in_win(r_cnt, 3 * HALF)) begin
                            w_sub_nx = 2'd2;
                            w_cnt_nx = CW'(1);
                        end else if (w_edge || past_win(r_cnt, 3 * HALF)) begin
                            w_state_nx = S_IDLE;
                        end
                    end
                    default: begin
                        if (w_fall && in_win(r_cnt, 3 * HALF)) begin
                            w_state_nx = S_SYNC;
                            w_cnt_nx   = CW'(1 + HALF);
                        end else if (w_edge || past_win(r_cnt, 3 * HALF)) begin
                            w_state_nx = S_IDLE;
                        end
                    end
                endcase
            end

            S_SYNC: begin
                if (w_mid) begin
                    w_cnt_nx = CW'(1);
                    if (w_rise) begin
                        w_state_nx    = S_DATA;
                        w_bits_nx     = 4'd0;
                        w_push_req    = r_hold_vld;
                        w_hold_vld_nx = 1'b0;
                    end else begin
                        w_state_nx = S_END;
                        w_sub_nx   = 2'd0;
                    end
                end else if (w_bit_to) begin
                    w_fault = E_MID;
                end
            end

            S_DATA: begin
                if (w_mid) begin
                    w_cnt_nx   = CW'(1);
                    w_shift_nx = {r_shift[8:0], w_rise};
                    w_bits_nx  = r_bits + 4'd1;
                    if (r_bits == 4'd9) w_state_nx = S_PARITY;
                end else if (w_bit_to) begin
                    w_fault = E_MID;
                end
            end

            S_PARITY: begin
                if (w_mid) begin
                    w_cnt_nx = CW'(1);
                    if ((1'b1 ^ (^r_shift) ^ w_rise) != PARITY_ODD) begin
                        w_fault = E_PAR;
                    end else begin
                        w_hold_nx     = r_shift;
                        w_hold_vld_nx = 1'b1;
                        w_state_nx    = S_SYNC;
                    end
                end else if (w_bit_to) begin
                    w_fault = E_MID;
                end
            end

            S_END: begin
                if (r_sub == 2'd0) begin
                    if (w_rise && in_win(r_cnt, HALF)) begin
                        w_sub_nx = 2'd1;
                        w_cnt_nx = CW'(1);
                    end else if (w_edge || past_win(r_cnt, HALF)) begin
                        w_fault = E_END;
                    end
                end else begin
                    if (w_fall && in_win(r_cnt, 2 * HALF)) begin
                        w_push_req    = r_hold_vld;
                        w_push_last   = 1'b1;
                        w_hold_vld_nx = 1'b0;
                        w_state_nx    = S_IDLE;
                        w_ones_nx     = 3'd0;
                    end else if (w_edge || past_win(r_cnt, 2 * HALF)) begin
                        w_fault = E_END;
                    end
                end
            end

            default: begin
                if (clear_error) begin
                    w_state_nx = S_IDLE;
                    w_err_nx   = 3'd0;
                    w_ones_nx  = 3'd0;
                end
            end
        endcase

        if (w_push_req && w_full && !w_pop) w_fault = E_OVF;
        w_push = w_push_req && !(w_full && !w_pop);

        if (w_fault != 3'd0) begin
            w_state_nx    = S_ERROR;
            w_err_nx      = w_fault;
            w_hold_vld_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_rx_d     <= 1'b0;
            r_state    <= S_IDLE;
            r_sub      <= 2'd0;
            r_cnt      <= '0;
            r_ones     <= 3'd0;
            r_shift    <= 10'd0;
            r_bits     <= 4'd0;
            r_hold     <= 10'd0;
            r_hold_vld <= 1'b0;
            r_err_code <= 3'd0;
        end else begin
            r_sync1    <= rx;
            r_sync2    <= r_sync1;
            r_rx_d     <= r_sync2;
            r_state    <= w_state_nx;
            r_sub      <= w_sub_nx;
            r_cnt      <= w_cnt_nx;
            r_ones     <= w_ones_nx;
            r_shift    <= w_shift_nx;
            r_bits     <= w_bits_nx;
            r_hold     <= w_hold_nx;
            r_hold_vld <= w_hold_vld_nx;
            r_err_code <= w_err_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {w_push_last, w_push_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head word is masked while empty so stale RAM never reaches the outputs
    assign data           = (r_count != '0) ? r_mem[r_rd][9:0] : 10'd0;
    assign last           = (r_count != '0) ? r_mem[r_rd][10]  : 1'b0;
    assign data_available = (r_count != '0);
    assign count          = r_count;
    assign active         = r_state inside {S_START, S_SYNC, S_DATA, S_PARITY, S_END};
    assign error          = (r_err_code != 3'd0);
    assign error_code     = r_err_code;

endmodule

// File: tb/tb_coax_frame_rx.sv
// tb/tb_coax_frame_rx.sv - randomized frame bench for coax_frame_rx with a queue-based reference model
module tb_coax_frame_rx;

    localparam int CPB  = 8;
    localparam int H    = CPB / 2;
    localparam bit PODD = 1'b0;

    localparam int F_NONE = 0;
    localparam int F_SYNC = 1;
    localparam int F_PAR  = 2;
    localparam int F_END  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b0;
    logic       clear_error = 1'b0;
    logic       read_a = 1'b0;
    logic       read_b = 1'b0;

    logic [9:0] data_a, data_b;
    logic       last_a, last_b, dav_a, dav_b, active_a, active_b, error_a, error_b;
    logic [3:0] count_a;
    logic [1:0] count_b;
    logic [2:0] code_a, code_b;

    coax_frame_rx #(.CLOCKS_PER_BIT(CPB), .DEPTH(8), .PARITY_ODD(PODD)) u_dut_a (
        .clk(clk), .reset(reset), .rx(rx), .read(read_a), .clear_error(clear_error),
        .data(data_a), .last(last_a), .data_available(dav_a), .count(count_a),
        .active(active_a), .error(error_a), .error_code(code_a)
    );

    coax_frame_rx #(.CLOCKS_PER_BIT(CPB), .DEPTH(2), .PARITY_ODD(PODD)) u_dut_b (
        .clk(clk), .reset(reset), .rx(rx), .read(read_b), .clear_error(clear_error),
        .data(data_b), .last(last_b), .data_available(dav_b), .count(count_b),
        .active(active_b), .error(error_b), .error_code(code_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] exp_q[$];
    int          exp_code = 0;
    logic [9:0]  fw[8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic par_bit(input logic [9:0] d);
        return logic'(($countones(d) + 1 + int'(PODD)) % 2);
    endfunction

    task automatic half(input logic lv);
        rx = lv;
        repeat (H) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (b) begin half(1'b0); half(1'b1); end
        else   begin half(1'b1); half(1'b0); end
    endtask

    task automatic hold_low(input int n);
        rx = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_words(input int m, input bit with_last);
        for (int j = 0; j < m; j++)
            exp_q.push_back({with_last && (j == m - 1), fw[j]});
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        half(1'b0); half(1'b0); half(1'b0);
        half(1'b1); half(1'b1); half(1'b1);
    endtask

    // Drives one frame from fw[0..n-1] and records what the receiver should end up holding
    task automatic send_frame(input int n, input int fault, input int fk);
        logic p;
        send_preamble();
        for (int k = 0; k < n; k++) begin
            if (fault == F_SYNC && k == fk) begin
                half(1'b0); half(1'b0);
                hold_low(30);
                expect_words(k - 1, 1'b0);
                exp_code = 1;
                return;
            end
            send_bit(1'b1);
            for (int i = 9; i >= 0; i--) send_bit(fw[k][i]);
            p = par_bit(fw[k]);
            if (fault == F_PAR && k == fk) p = ~p;
            send_bit(p);
            if (fault == F_PAR && k == fk) begin
                hold_low(30);
                expect_words(k, 1'b0);
                exp_code = 2;
                return;
            end
        end
        send_bit(1'b0);
        if (fault == F_END) begin
            hold_low(30);
            expect_words(n - 1, 1'b0);
            exp_code = 3;
            return;
        end
        half(1'b1); half(1'b1);
        hold_low(30);
        expect_words(n, 1'b1);
    endtask

    task automatic pulse_read_a();
        read_a = 1'b1;
        @(posedge clk); #1;
        read_a = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_error = 1'b1;
        @(posedge clk); #1;
        clear_error = 1'b0;
    endtask

    task automatic drain_and_check(input string tag);
        logic [10:0] e;
        int          left;
        check_eq({tag, ".error_code"}, 32'(code_a), 32'(exp_code));
        check_eq({tag, ".error"}, 32'(error_a), 32'(exp_code != 0));
        check_eq({tag, ".count"}, 32'(count_a), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            left = exp_q.size();
            check_eq({tag, ".avail"}, 32'(dav_a), 32'd1);
            check_eq({tag, ".data"}, 32'(data_a), 32'(e[9:0]));
            check_eq({tag, ".last"}, 32'(last_a), 32'(e[10]));
            pulse_read_a();
            check_eq({tag, ".count_after_read"}, 32'(count_a), 32'(left));
        end
        check_eq({tag, ".empty"}, 32'(dav_a), 32'd0);
        if (exp_code != 0) begin
            pulse_clear();
            check_eq({tag, ".cleared_error"}, 32'(error_a), 32'd0);
            check_eq({tag, ".cleared_code"}, 32'(code_a), 32'd0);
            check_eq({tag, ".cleared_active"}, 32'(active_a), 32'd0);
            exp_code = 0;
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f, fk;

        repeat (4) @(posedge clk);
        #1;
        check_eq("rst.data", 32'(data_a), 32'd0);
        check_eq("rst.last", 32'(last_a), 32'd0);
        check_eq("rst.avail", 32'(dav_a), 32'd0);
        check_eq("rst.count", 32'(count_a), 32'd0);
        check_eq("rst.active", 32'(active_a), 32'd0);
        check_eq("rst.error", 32'(error_a), 32'd0);
        check_eq("rst.code", 32'(code_a), 32'd0);
        reset = 1'b1;
        hold_low(10);

        fw[0] = 10'b0110110011;
        send_frame(1, F_NONE, 0);
        drain_and_check("single");

        fw[0] = 10'b0110110011;
        fw[1] = 10'b1011011011;
        send_frame(2, F_NONE, 0);
        pulse_clear();
        check_eq("two.clear_noop_count", 32'(count_a), 32'd2);
        drain_and_check("two");

        fw[0] = 10'b0110110011;
        send_frame(1, F_PAR, 0);
        drain_and_check("bad_parity");

        send_frame(1, F_SYNC, 0);
        drain_and_check("no_sync_edge");

        fw[0] = 10'b1100101001;
        send_frame(1, F_END, 0);
        drain_and_check("bad_end");

        for (int it = 0; it < 20; it++) begin
            n  = $urandom_range(1, 3);
            f  = $urandom_range(0, 5);
            if (f > 3) f = F_NONE;
            fk = $urandom_range(0, n - 1);
            for (int k = 0; k < n; k++) fw[k] = 10'($urandom);
            send_frame(n, f, fk);
            drain_and_check($sformatf("rand%0d", it));
        end

        fw[0] = 10'($urandom);
        send_frame(1, F_NONE, 0);
        send_preamble();
        send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check_eq("midframe.active", 32'(active_a), 32'd1);
        check_eq("midframe.count", 32'(count_a), 32'd1);
        reset = 1'b0;
        rx    = 1'b0;
        #1;
        check_eq("async_rst.data", 32'(data_a), 32'd0);
        check_eq("async_rst.last", 32'(last_a), 32'd0);
        check_eq("async_rst.avail", 32'(dav_a), 32'd0);
        check_eq("async_rst.count", 32'(count_a), 32'd0);
        check_eq("async_rst.active", 32'(active_a), 32'd0);
        check_eq("async_rst.error", 32'(error_a), 32'd0);
        exp_q.delete();
        exp_code = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        hold_low(10);
        fw[0] = 10'b0110110011;
        fw[1] = 10'($urandom);
        send_frame(2, F_NONE, 0);
        drain_and_check("after_reset");

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        hold_low(10);
        for (int k = 0; k < 4; k++) fw[k] = 10'($urandom);
        send_frame(4, F_NONE, 0);
        check_eq("ovf.code", 32'(code_b), 32'd4);
        check_eq("ovf.error", 32'(error_b), 32'd1);
        check_eq("ovf.active", 32'(active_b), 32'd0);
        check_eq("ovf.count", 32'(count_b), 32'd2);
        check_eq("ovf.data0", 32'(data_b), 32'(fw[0]));
        check_eq("ovf.last0", 32'(last_b), 32'd0);
        read_b = 1'b1;
        @(posedge clk); #1;
        read_b = 1'b0;
        check_eq("ovf.data1", 32'(data_b), 32'(fw[1]));
        check_eq("ovf.last1", 32'(last_b), 32'd0);
        read_b = 1'b1;
        @(posedge clk); #1;
        read_b = 1'b0;
        check_eq("ovf.empty", 32'(dav_b), 32'd0);
        drain_and_check("deep_four");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coax_frame_rx.md
# coax_frame_rx

Buffered, parametrised 3270 coax receiver. It decodes Manchester-encoded frames into a DEPTH-entry word FIFO and tags the final word of each frame. Errors are reported through a sticky error code that is cleared without a full reset. It sits between the coax line front end (digitised `rx`) and the host-side interface logic, and lets multi-word frames be received without per-word host service.

## Interface
- `CLOCKS_PER_BIT`, 8: clocks per bit cell; even, ≥8.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `PARITY_ODD`, 0: 0 = ones across sync+data+parity even; 1 = odd.

Ports (name, direction, width, meaning):
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx` in 1: raw line input, asynchronous to `clk`.
- `read` in 1: pop the FIFO head.
- `clear_error` in 1: leave ERROR state.
- `data` out 10: FIFO head word, MSB = first data bit.
- `last` out 1: head word ends a frame.
- `data_available` out 1: FIFO non-empty.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `active` out 1: frame in progress (START_SEQ through END_SEQ).
- `error` out 1: error latched.
- `error_code` out 3: 1 = LOSS_OF_MID_BIT_TRANSITION, 2 = PARITY, 3 = INVALID_END_SEQUENCE, 4 = OVERFLOW.

## Operation

Line input:
- `rx` passes through a 2-flop synchroniser. All decoding uses the synchronised signal.
- Bit 1 = low first half, high second half. Bit 0 = high then low.
- A mid-bit edge is accepted within ±CLOCKS_PER_BIT/4 of the expected point. The bit clock re-centres on every accepted mid-bit edge.

States:
- IDLE: hunt for line quiesce, i.e. 5 consecutive bit-1 cells. Any other pattern restarts the hunt. No error is ever raised from IDLE.
- START_SEQ: code violation, line low for 3 half-bits then high for 3 half-bits (±tolerance). A mismatch returns to IDLE silently.
- SYNC_BIT: bit 1 → DATA_BIT. Bit 0 → END_SEQ. No mid-bit edge → ERROR code 1.
- DATA_BIT: 10 bits, shifted MSB-first. A missing mid-bit edge → ERROR code 1.
- PARITY_BIT: parity checked per PARITY_ODD.
  - Mismatch → ERROR code 2.
  - Missing edge → code 1.
  - Otherwise the word goes to the holding register and the state moves to SYNC_BIT.
- END_SEQ: line high for 2 half-bits (±tolerance) then falls.
  - Valid: holding word pushed with `last`=1, state → IDLE.
  - Anything else: ERROR code 3.
- ERROR: `rx` ignored. Stays until `clear_error`, then → IDLE.

Holding register:
- A completed word is held until the next sync bit, then pushed with `last`=0.
- On error, the holding word is discarded. Words already in the FIFO stay readable.

FIFO:
- First-word-fall-through.
- A push with `count`==DEPTH and no simultaneous `read` → ERROR code 4, and the word is dropped.
- Simultaneous push and read when full: both happen, and `count` stays at DEPTH.
- `read` when empty is ignored.
- Pointer wrap-around is modulo DEPTH.

## Timing
- Reset values: `data`=0, `last`=0, `data_available`=0, `count`=0, `active`=0, `error`=0, `error_code`=0, state IDLE. FIFO pointers are zeroed.
- Latency: 2 synchroniser cycles, plus 1 registered-output cycle after the decoding event.
- `error`/`error_code` assert 1 cycle after detection.
- Push after the valid end-sequence falling edge: `data_available` rises on the following cycle.
- `read` sampled high → `data`/`last` show the next entry, or `data_available` falls, on the next cycle.
- `clear_error` → `error`=0, `error_code`=0 and state IDLE next cycle. The FIFO is untouched. `clear_error` outside ERROR has no effect.
- Reset mid-frame: immediate asynchronous return to all reset values. FIFO contents are discarded.

## Test plan
- Assert `reset` low mid-data-bit → all outputs 0 asynchronously; state IDLE; a frame received afterwards decodes correctly.
- Single word 0110110011, parity 1, valid end → `data`=10'b0110110011, `last`=1, `count`=1; pulse `read` → `data_available`=0 next cycle.
- Two words, 0110110011 (parity 1) then 1011011011 (parity 0), valid end → entries (0110110011, `last`=0) then (1011011011, `last`=1); `count` 2→1→0 across reads.
- Word 0110110011 with parity 0 → `error`=1, `error_code`=2, `count`=0; pulse `clear_error` → `error`=0 and state IDLE.
- Each of the following → ERROR with the stated code:
  - Sync bit sent with no mid-bit transition → code 1.
  - Valid word followed by bit 0 then `rx` held low → code 3.
- DEPTH=2, four-word frame, no reads → ERROR code 4 at the 4th sync bit; `count`=2; the two FIFO words are intact and readable.
